// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants and types for the round-robin ALU scheduler.
//   OP_*        ALU opcodes (ADD, SUB, OR, AND)
//   sched_state_t  scheduler FSM states
//   FLAG_*      bit positions inside the 4-bit {V,C,Z,N} flag vector
package alu_sched_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/alu.sv
// alu: combinational ALU shared by the scheduler.
//   a, b    operands (WA / WB bits)
//   op      OP_ADD / OP_SUB / OP_OR / OP_AND
//   result  WR-bit result
//   v,c,z,n signed overflow, carry out, zero, negative
// SUB is computed as a + ~b + 1, so c is the carry out of that sum
// (c=1 means no borrow, i.e. a >= b unsigned). Logic ops clear v and c.
// The datapath assumes WA == WB == WR.
module alu
   import alu_sched_pkg::*;
#(
   parameter int WA = 8,
   parameter int WB = 8,
   parameter int WR = 8
) (
   input  logic [WA-1:0] a,
   input  logic [WB-1:0] b,
   input  logic [1:0]    op,
   output logic [WR-1:0] result,
   output logic          v,
   output logic          c,
   output logic          z,
   output logic          n
);

   logic [WR:0] sum;

   always_comb begin
      sum = '0;
      v   = 1'b0;
      c   = 1'b0;
      case (op)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            c   = sum[WR];
            v   = (a[WA-1] == b[WB-1]) && (sum[WR-1] != a[WA-1]);
         end
         OP_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + (WR+1)'(1);
            c   = sum[WR];
            v   = (a[WA-1] != b[WB-1]) && (sum[WR-1] != a[WA-1]);
         end
         OP_OR:   sum = {1'b0, a | b};
         default: sum = {1'b0, a & b};
      endcase
   end

   assign result = sum[WR-1:0];
   assign z      = (sum[WR-1:0] == '0);
   assign n      = sum[WR-1];

endmodule

// File: rtl/alu_rr_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        request vector
//   ptr        highest-priority index; search runs upward from ptr with wrap
//   enable     when low, no grant is issued
//   grant      one-hot grant (or zero)
//   grant_idx  binary index of the granted requester (0 when no grant)
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (enable && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx[IDW-1:0];
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU among NREQ requesters.
// A round-robin arbiter accepts one command in IDLE, the command is latched,
// executed in EXEC, and the registered result is offered in RESP until the
// consumer takes it.
//   clk, reset                   clock, async active-high reset
//   req_valid/req_ready          per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op           flat per-requester operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready          response handshake
//   rsp_id, rsp_result, rsp_flags  owner index, registered result and {V,C,Z,N}
// Optional build macro ALU_RR_STICKY_FLAGS_EN adds sticky_flags (OR of all
// captured flags) and sticky_clr.
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_result,
`ifdef ALU_RR_STICKY_FLAGS_EN
   output logic [3:0]        sticky_flags,
   input  logic [0:0]        sticky_clr,
`endif
   output logic [3:0]        rsp_flags
);

   sched_state_t    state;
   logic [IDW-1:0]  ptr;
   logic [W-1:0]    lat_a, lat_b;
   logic [1:0]      lat_op;
   logic [IDW-1:0]  lat_id;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic [W-1:0]    alu_result;
   logic            alu_v, alu_c, alu_z, alu_n;
   logic [3:0]      alu_flags;

   // Reset gates the enable so req_ready reads 0 while reset is held.
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .enable    ((state == IDLE) && !reset),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;

   alu #(.WA(W), .WB(W), .WR(W)) u_alu (
      .a      (lat_a),
      .b      (lat_b),
      .op     (lat_op),
      .result (alu_result),
      .v      (alu_v),
      .c      (alu_c),
      .z      (alu_z),
      .n      (alu_n)
   );

   always_comb begin
      alu_flags         = '0;
      alu_flags[FLAG_V] = alu_v;
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_Z] = alu_z;
      alu_flags[FLAG_N] = alu_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_op     <= '0;
         lat_id     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  lat_a  <= req_a[int'(grant_idx)*W +: W];
                  lat_b  <= req_b[int'(grant_idx)*W +: W];
                  lat_op <= req_op[int'(grant_idx)*2 +: 2];
                  lat_id <= grant_idx;
                  ptr    <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_flags  <= alu_flags;
               rsp_id     <= lat_id;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_RR_STICKY_FLAGS_EN
   // A clear coinciding with a capture keeps only the new flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sticky_flags <= '0;
      else if (state == EXEC)
         sticky_flags <= sticky_clr[0] ? alu_flags : (sticky_flags | alu_flags);
      else if (sticky_clr[0])
         sticky_flags <= '0;
   end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler (NREQ=4, W=8).
// A transaction-level model (pointer, busy phase, expected-response queue)
// checks every cycle; table vectors and directed sequences cover corners.
module tb_alu_rr_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ*2-1:0] req_op = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_result;
   logic [3:0]        rsp_flags;
`ifdef ALU_RR_STICKY_FLAGS_EN
   logic [3:0]        sticky_flags;
   logic [0:0]        sticky_clr = 1'b0;
`endif

   alu_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
`ifdef ALU_RR_STICKY_FLAGS_EN
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr),
`endif
      .rsp_flags  (rsp_flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         id;
      logic [7:0] res;
      logic [3:0] flags;
   } rsp_t;

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic [7:0] res;
      logic [3:0] flags;   // {V,C,Z,N}
   } vec_t;

   // model state
   rsp_t q[$];
   int   mptr  = 0;
   int   phase = 0;        // 0 idle, 1 executing, 2 response offered
   int   cyc   = 0;
   int   dut_grants[$];
   int   rsp_cycles[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Spec-level ALU: plain integer arithmetic. Returns {V,C,Z,N, result}.
   function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
      int ua, ub, sa, sb, r, s;
      logic c, v;
      logic [7:0] res;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      s = 0; c = 1'b0;
      case (op)
         2'd0: begin r = ua + ub; s = sa + sb; c = (r > 255); end
         2'd1: begin r = ua - ub; s = sa - sb; c = (ua >= ub); end
         2'd2: r = ua | ub;
         default: r = ua & ub;
      endcase
      res = r[7:0];
      v = (op < 2) && (s > 127 || s < -128);
      return {v, c, (res == 8'd0), res[7], res};
   endfunction

   // Called at a negedge with inputs already driven; checks, updates model,
   // and returns at the next negedge.
   task automatic step_cycle();
      logic [3:0]  eg;
      logic [11:0] r;
      rsp_t        e;
      int          g;
      #1;
      eg = '0; g = -1;
      if (phase == 0)
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
         end
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", req_ready, eg);
      chk("rsp_valid", rsp_valid, phase == 2);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
      if (rsp_valid && rsp_ready) rsp_cycles.push_back(cyc);
      if (phase == 2 && q.size() > 0) begin
         chk("rsp_id", rsp_id, q[0].id);
         chk("rsp_result", rsp_result, q[0].res);
         chk("rsp_flags", rsp_flags, q[0].flags);
      end
      if (phase == 2) begin
         if (rsp_ready) begin
            void'(q.pop_front());
            phase = 0;
         end
      end else if (phase == 1) begin
         phase = 2;
      end else if (g >= 0) begin
         r = alu_ref(req_a[g*8 +: 8], req_b[g*8 +: 8], req_op[g*2 +: 2]);
         e.id = g; e.res = r[7:0]; e.flags = r[11:8];
         q.push_back(e);
         mptr  = (g + 1) % NREQ;
         phase = 1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '1;
      #1;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_result", rsp_result, 8'h00);
      chk("rst_rsp_flags", rsp_flags, 4'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      req_valid = '0;
      q.delete(); mptr = 0; phase = 0;
   endtask

   task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      req_op[id*2 +: 2] = op;
   endtask

   // Let any in-flight command finish; bounded.
   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10 && phase != 0; i++) step_cycle();
      if (phase != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=%0d expected=0", phase);
      end
   endtask

   task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op);
      drive(id, a, b, op);
      step_cycle();
      req_valid = '0;
      step_cycle();
      step_cycle();
   endtask

   vec_t vt[7];
   int   exp_order[5];

   initial begin
      vt[0] = '{0, 8'h7F, 8'h01, 2'd0, 8'h80, 4'b1001};
      vt[1] = '{2, 8'h05, 8'h05, 2'd1, 8'h00, 4'b0110};
      vt[2] = '{3, 8'hFF, 8'h01, 2'd0, 8'h00, 4'b0110};
      vt[3] = '{1, 8'h80, 8'h01, 2'd1, 8'h7F, 4'b1100};
      vt[4] = '{0, 8'h3C, 8'hC3, 2'd2, 8'hFF, 4'b0001};
      vt[5] = '{2, 8'hF0, 8'h0F, 2'd3, 8'h00, 4'b0010};
      vt[6] = '{3, 8'h00, 8'h01, 2'd1, 8'hFF, 4'b0001};
      exp_order = '{0, 1, 2, 3, 0};

      do_reset();

      // Table vectors: single requester, response two edges after handshake cycle.
      foreach (vt[i]) begin
         drive(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
         step_cycle();            // handshake cycle
         req_valid = '0;
         step_cycle();            // EXEC
         #1;
         chk($sformatf("vec%0d_valid", i), rsp_valid, 1'b1);
         chk($sformatf("vec%0d_id", i), rsp_id, vt[i].id);
         chk($sformatf("vec%0d_result", i), rsp_result, vt[i].res);
         chk($sformatf("vec%0d_flags", i), rsp_flags, vt[i].flags);
         step_cycle();            // RESP, consumed
      end

      // All requesters valid from pointer 0: grants 0,1,2,3,0, responses 3 cycles apart.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*8 +: 8] = 8'(8'h10 * i + 3);
         req_b[i*8 +: 8] = 8'(8'h21 + i);
         req_op[i*2 +: 2] = 2'(i);
      end
      dut_grants.delete(); rsp_cycles.delete();
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < 15; i++) step_cycle();
      chk("rr_grant_count", dut_grants.size(), 5);
      for (int i = 0; i < 5 && i < dut_grants.size(); i++)
         chk($sformatf("rr_order%0d", i), dut_grants[i], exp_order[i]);
      chk("rr_rsp_count", rsp_cycles.size(), 5);
      for (int i = 1; i < rsp_cycles.size(); i++)
         chk($sformatf("rr_spacing%0d", i), rsp_cycles[i] - rsp_cycles[i-1], 3);
      drain();

      // Consumer stall: hold rsp_ready low 5 cycles in RESP with everyone requesting.
      rsp_ready = 1'b0;
      drive(1, 8'h12, 8'h34, 2'd0);
      step_cycle();
      req_valid = '1;
      step_cycle();
      for (int i = 0; i < 5; i++) step_cycle();
      rsp_ready = 1'b1;
      step_cycle();                // response consumed
      step_cycle();                // back in IDLE: next grant follows pointer
      drain();

      // Reset during EXEC drops the command; a following request completes.
      drive(2, 8'h40, 8'h40, 2'd0);
      step_cycle();                // accepted, DUT now in EXEC
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      chk("midrst_req_ready", req_ready, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      q.delete(); mptr = 0; phase = 0;
      req_valid = '0;
      step_cycle();                // idle, nothing emitted
      req_valid = 4'b1010;
      req_a[8 +: 8] = 8'h0A; req_b[8 +: 8] = 8'h03; req_op[2 +: 2] = 2'd1;
      #1;
      chk("postrst_grant", req_ready, 4'b0010);
      step_cycle();
      req_valid = '0;
      step_cycle();
      #1;
      chk("postrst_result", rsp_result, 8'h07);
      chk("postrst_id", rsp_id, 2'd1);
      step_cycle();
      drain();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         req_valid = 4'($urandom_range(0, 15));
         req_a     = $urandom;
         req_b     = $urandom;
         req_op    = 8'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         step_cycle();
      end
      drain();

`ifdef ALU_RR_STICKY_FLAGS_EN
      do_reset();
      #1;
      chk("sticky_reset", sticky_flags, 4'b0000);
      @(negedge clk);
      run_one(0, 8'hFF, 8'h01, 2'd0);
      run_one(1, 8'h80, 8'h00, 2'd2);
      #1;
      chk("sticky_accum", sticky_flags, 4'b0111);
      @(negedge clk);
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      #1;
      chk("sticky_clear", sticky_flags, 4'b0000);
      @(negedge clk);
`else
      run_one(3, 8'h01, 8'h02, 2'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0t expected=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
